if_id_buffer: RTL
=================

Name: if_id_buffer

Overview:
- Fetch-to-decode decoupling buffer for the segmented RV32I core.
- Sits directly downstream of PC plus instruction memory: captures each fetched {pc, instr} pair and presents it to the decode stage.
- Small FIFO with valid/ready handshakes on both sides. Back-pressure from decode stalls the PC via in_ready.
- flush discards all queued fetches on a taken branch or jump.

Parameters:
- XLEN, 32, width of pc and instr fields.
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h0000_0013, instruction word driven on out_instr when empty (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  fetch side presents a valid pc/instr pair.
- in_ready  output  1  buffer can accept; drives the PC stall (PC holds when low).
- in_pc  input  XLEN  PCOutput of the PC register.
- in_instr  input  XLEN  instruction word read at in_pc.
- flush  input  1  discard all entries (redirect from execute).
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts head this cycle.
- out_pc  output  XLEN  head pc.
- out_pc_plus4  output  XLEN  head pc + 4, modulo 2^XLEN.
- out_instr  output  XLEN  head instruction.
- out_misaligned  output  1  head pc[1:0] != 0 (see Optional Feature).
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage: register array of DEPTH entries, read pointer rd_ptr, write pointer wr_ptr, occupancy cnt. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Ready/valid decode:
  - in_ready = (cnt != DEPTH). Purely combinational from state; no dependence on out_ready.
  - out_valid = (cnt != 0).
- Transfer conditions:
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready && !flush.
- Outputs: read combinationally from entry[rd_ptr].
  - When empty: out_pc = 0, out_pc_plus4 = 4, out_instr = NOP_INSTR, out_misaligned = 0.
- Latency: a push at edge N is visible as out_valid=1 after edge N. There is no same-cycle bypass from input to output.
- Per-edge update:
  - push only: write entry[wr_ptr], wr_ptr+1, cnt+1.
  - pop only: rd_ptr+1, cnt-1.
  - push and pop together (0 < cnt < DEPTH): both pointers advance, cnt unchanged.
  - Full: in_ready=0, so only a pop can occur. Freed space is visible as in_ready=1 the following cycle.
  - Empty: out_valid=0, so no pop. A push into an empty buffer is legal.
- flush (highest priority after reset):
  - Next edge: rd_ptr = wr_ptr = 0, cnt = 0.
  - Same-cycle push and pop are both suppressed.
  - Entry contents are not cleared; they are don't-care.
- reset low at an edge: rd_ptr = wr_ptr = cnt = 0. Overrides flush and push, including mid-stream.
  - Resulting outputs: in_ready=1, out_valid=0, count=0, out_instr=NOP_INSTR, out_pc=0, out_pc_plus4=4, out_misaligned=0.
- No X propagation: out_* hold the empty defaults whenever cnt==0.

Optional Feature:
- Macro IF_ID_MISALIGN_CHECK_EN.
- Defined:
  - Each entry stores an extra bit, misaligned = (in_pc[1:0] != 2'b00), computed at push.
  - out_misaligned reflects the head entry's bit.
- Undefined:
  - No extra storage bit.
  - out_misaligned tied to 0; the port is always present.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN and NOP_INSTR constants.
  - typedef struct packed fetch_entry_t {pc, instr, misaligned}.
- No sub-module. The FIFO is small enough to live inline; pointer and count logic sits in one always_ff, output muxing in one always_comb.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> out_valid=0, in_ready=1, count=0, out_instr=32'h00000013, out_pc_plus4=4.
- Single push: in_pc=32'h0000_0004, in_instr=32'h00500093, out_ready=0 -> next cycle out_valid=1, out_pc=4, out_pc_plus4=8, out_instr=32'h00500093, count=1.
- Fill and back-pressure: push pc 0, then pc 4, with out_ready=0 -> count=2, in_ready=0. A third in_valid with pc 8 is not accepted. Raise out_ready -> pops pc 0, then pc 4. pc 8 is accepted one cycle after in_ready returns 1.
- Streaming: in_valid=1 and out_ready=1 continuously for pcs 0,4,8,...,0x1C -> outputs appear in order, one cycle after each push, count stays 1.
- Flush mid-stream: count=2 with pcs 0x10 and 0x14; assert flush with in_valid=1, pc=0x18 -> next cycle count=0, out_valid=0; pc 0x18 is not stored.
- Reset priority: count=1; drive reset=0, flush=0, in_valid=1 -> count=0 after the edge. With IF_ID_MISALIGN_CHECK_EN defined, a push of pc=32'h0000_0006 then gives out_misaligned=1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the segmented RV32I core.
//   XLEN          : native register / address width
//   NOP_INSTR     : canonical no-op (addi x0,x0,0), used as the empty filler
//   fetch_entry_t : one fetched {pc, instr, misaligned} record
//   pc_misaligned : helper flagging a pc that is not word aligned
// -----------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;

  // A fetch address is misaligned when either of its two low bits is set.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
// Fetch-to-decode decoupling FIFO. Captures each fetched {pc, instr} pair and
// presents the oldest one to decode. in_ready low stalls the PC; flush drops
// every queued fetch after a taken branch/jump.
//
// Optional build macro: IF_ID_MISALIGN_CHECK_EN
//   defined   : each entry carries a misaligned bit computed at push and
//               out_misaligned reports the head entry's bit
//   undefined : no extra storage, out_misaligned is tied low
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous active-low reset
//   in_valid       in   fetch presents a pc/instr pair
//   in_ready       out  buffer has room (PC holds when low)
//   in_pc          in   pc of the fetched instruction
//   in_instr       in   instruction word read at in_pc
//   flush          in   discard all entries
//   out_valid      out  head entry valid
//   out_ready      in   decode consumes the head this cycle
//   out_pc         out  head pc (0 when empty)
//   out_pc_plus4   out  head pc + 4 (4 when empty)
//   out_instr      out  head instruction (NOP_INSTR when empty)
//   out_misaligned out  head pc[1:0] != 0 (0 when empty or feature off)
//   count          out  occupancy
// -----------------------------------------------------------------------------
module if_id_buffer #(
  parameter int              XLEN      = rv32i_pkg::XLEN,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_instr,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_pc_plus4,
  output logic [XLEN-1:0]           out_instr,
  output logic                      out_misaligned,
  output logic [$clog2(DEPTH):0]    count
);

  import rv32i_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [XLEN-1:0] instr_mem_r [DEPTH];
`ifdef IF_ID_MISALIGN_CHECK_EN
  logic            mis_mem_r   [DEPTH];
`endif

  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          push_s;
  logic          pop_s;

  // Handshake decode; flush suppresses both transfers in its cycle.
  always_comb begin
    in_ready  = (cnt_r != CW'(DEPTH));
    out_valid = (cnt_r != CW'(0));
    push_s    = in_valid && in_ready && !flush;
    pop_s     = out_valid && out_ready && !flush;
  end

  // Pointer and occupancy state; reset outranks flush, flush outranks transfers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      cnt_r    <= CW'(0);
    end else if (flush) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      cnt_r    <= CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because cnt gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= in_pc;
      instr_mem_r[wr_ptr_r] <= in_instr;
`ifdef IF_ID_MISALIGN_CHECK_EN
      mis_mem_r[wr_ptr_r]   <= pc_misaligned(in_pc[1:0]);
`endif
    end
  end

  // Head presentation with fixed empty defaults so no stale data leaks out.
  always_comb begin
    out_pc         = XLEN'(0);
    out_instr      = NOP_INSTR;
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_pc    = pc_mem_r[rd_ptr_r];
      out_instr = instr_mem_r[rd_ptr_r];
`ifdef IF_ID_MISALIGN_CHECK_EN
      out_misaligned = mis_mem_r[rd_ptr_r];
`else
      out_misaligned = 1'b0;
`endif
    end else begin
      out_pc         = XLEN'(0);
      out_instr      = NOP_INSTR;
      out_misaligned = 1'b0;
    end
    out_pc_plus4 = out_pc + XLEN'(4);
  end

  assign count = cnt_r;

endmodule
